// File: rtl/param_receiver.sv
// ---------------------------------------------------------------------------
// param_receiver -- oversampling asynchronous serial receiver with a
// four-phase req/ack output handshake.
//
// Frame format: one start bit (0), DATA_BITS payload bits LSB first,
// an optional parity bit (PARITY_MODE 0 none, 1 even, 2 odd), then
// STOP_BITS stop bits (1). One bit period is 8 ticks and one tick is
// CLKS_PER_TICK clocks.
//
// Optional feature macro: RX_MAJORITY_EN
//   defined   : every bit is the 2-of-3 vote of the samples taken at
//               phases 3, 4 and 5; the decision is made at phase 5.
//   undefined : every bit is a single sample taken at phase 4.
//
// Ports
//   clk         in   single clock, all logic on posedge
//   clr         in   synchronous active-high reset
//   rcv         in   asynchronous serial line, idle high
//   ack         in   consumer acknowledge
//   req         out  a received frame is available on data/flags
//   data        out  received payload (DATA_BITS wide)
//   parity_err  out  parity mismatch on the delivered frame
//   framing_err out  a stop bit was sampled 0 on the delivered frame
//   overrun     out  sticky: one or more frames were dropped
//   dbg_state   out  current FSM state (0 IDLE,1 START,2 DATA,3 PARITY,4 STOP)
//
// Handshake (four-phase): req rises one clock after a frame completes
// while req=0 and ack=0. data and the error flags are held while req=1.
// req falls the clock after ack=1 is sampled, and no new req is raised
// while ack=1. A frame completing while req=1 or ack=1 is dropped and
// sets overrun; overrun clears when the next frame is delivered.
// ---------------------------------------------------------------------------
module param_receiver #(
  parameter int DATA_BITS     = 8,
  parameter int PARITY_MODE   = 0,
  parameter int STOP_BITS     = 1,
  parameter int CLKS_PER_TICK = 579
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 rcv,
  input  logic                 ack,
  output logic                 req,
  output logic [DATA_BITS-1:0] data,
  output logic                 parity_err,
  output logic                 framing_err,
  output logic                 overrun,
  output logic [2:0]           dbg_state
);

  localparam int TW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(CLKS_PER_TICK - 1);
  localparam logic [3:0]    LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                 r_state;
  logic                   r_sync1, r_sync2, r_sync3;
  logic [TW-1:0]          r_tick_cnt;
  logic [2:0]             r_phase;
  logic [3:0]             r_bit_cnt;
  logic                   r_stop_cnt;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_par_bit;
  logic                   r_frm;
  logic                   r_req;
  logic [DATA_BITS-1:0]   r_data;
  logic                   r_pe;
  logic                   r_fe;
  logic                   r_ovr;

  logic w_fall, w_tick, w_samp, w_bit, w_adv, w_done;
  logic w_par_xor, w_par_err, w_frm_err;

  // r_sync3 is the previous synchronized value, used only for edge detect.
  assign w_fall = r_sync3 & ~r_sync2;
  assign w_tick = (r_tick_cnt == TICK_MAX);
  assign w_adv  = w_tick && (r_phase == 3'd7);

`ifdef RX_MAJORITY_EN
  logic r_vote3, r_vote4;

  // Early samples for the vote; the third sample is the live value at phase 5.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_vote3 <= 1'b1;
      r_vote4 <= 1'b1;
    end else begin
      if (w_tick && (r_phase == 3'd3)) r_vote3 <= r_sync2;
      if (w_tick && (r_phase == 3'd4)) r_vote4 <= r_sync2;
    end
  end

  assign w_samp = w_tick && (r_phase == 3'd5);
  assign w_bit  = (r_vote3 & r_vote4) | (r_vote3 & r_sync2) | (r_vote4 & r_sync2);
`else
  assign w_samp = w_tick && (r_phase == 3'd4);
  assign w_bit  = r_sync2;
`endif

  assign w_par_xor = (^r_shift) ^ r_par_bit;
  assign w_par_err = (PARITY_MODE == 1) ? w_par_xor :
                     (PARITY_MODE == 2) ? ~w_par_xor : 1'b0;

  // The last stop bit's own sample must be folded in on the completing cycle.
  assign w_frm_err = r_frm | ~w_bit;
  assign w_done    = (r_state == S_STOP) && w_samp && (r_stop_cnt == LAST_STOP);

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state    <= S_IDLE;
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_sync3    <= 1'b1;
      r_tick_cnt <= '0;
      r_phase    <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_shift    <= '0;
      r_par_bit  <= 1'b0;
      r_frm      <= 1'b0;
      r_req      <= 1'b0;
      r_data     <= '0;
      r_pe       <= 1'b0;
      r_fe       <= 1'b0;
      r_ovr      <= 1'b0;
    end else begin
      r_sync1 <= rcv;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;

      // Tick divider free-runs, but is re-aligned to the start edge.
      if ((r_state == S_IDLE) && w_fall) r_tick_cnt <= '0;
      else if (w_tick)                   r_tick_cnt <= '0;
      else                               r_tick_cnt <= r_tick_cnt + 1'b1;

      // Phase counter only runs inside a frame; 3-bit wrap gives 7 -> 0.
      if (r_state == S_IDLE) r_phase <= '0;
      else if (w_tick)       r_phase <= r_phase + 3'd1;

      case (r_state)
        S_IDLE: begin
          if (w_fall) begin
            r_state    <= S_START;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_par_bit  <= 1'b0;
            r_frm      <= 1'b0;
          end
        end
        S_START: begin
          if (w_samp && w_bit) r_state <= S_IDLE;   // false start
          else if (w_adv)      r_state <= S_DATA;
        end
        S_DATA: begin
          if (w_samp) r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
          if (w_adv) begin
            if (r_bit_cnt == LAST_BIT) begin
              r_bit_cnt <= '0;
              r_state   <= (PARITY_MODE == 0) ? S_STOP : S_PARITY;
            end else begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end
        end
        S_PARITY: begin
          if (w_samp) r_par_bit <= w_bit;
          if (w_adv)  r_state   <= S_STOP;
        end
        S_STOP: begin
          if (w_samp) begin
            if (!w_bit) r_frm <= 1'b1;
            // Leave right after the last stop sample so a following start
            // edge arriving early is not missed.
            if (r_stop_cnt == LAST_STOP) r_state <= S_IDLE;
          end
          if (w_adv) r_stop_cnt <= r_stop_cnt + 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase

      if (r_req && ack) r_req <= 1'b0;

      if (w_done) begin
        if (!r_req && !ack) begin
          r_data <= r_shift;
          r_pe   <= w_par_err;
          r_fe   <= w_frm_err;
          r_req  <= 1'b1;
          r_ovr  <= 1'b0;
        end else begin
          r_ovr  <= 1'b1;
        end
      end
    end
  end

  assign req         = r_req;
  assign data        = r_data;
  assign parity_err  = r_pe;
  assign framing_err = r_fe;
  assign overrun     = r_ovr;
  assign dbg_state   = r_state;

endmodule

// File: doc/param_receiver.md
PARAM_RECEIVER -- requirements
Module: param_receiver

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame, legal range 5..9.
REQ-002 SHALL have parameter PARITY_MODE, default 0, meaning 0 none, 1 even, 2 odd.
REQ-003 SHALL have parameter STOP_BITS, default 1, meaning stop bits checked, legal values 1 or 2.
REQ-004 SHALL have parameter CLKS_PER_TICK, default 579, meaning clk cycles per oversample tick, minimum 1.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all logic on posedge.
REQ-006 SHALL have port clr, input, 1, meaning reset, synchronous and active-high.
REQ-007 SHALL have port rcv, input, 1, meaning asynchronous serial line, idle high.
REQ-008 SHALL have port ack, input, 1, meaning consumer acknowledge.
REQ-009 SHALL have port req, output, 1, meaning a frame is available.
REQ-010 SHALL have port data, output, DATA_BITS, meaning received payload.
REQ-011 SHALL have port parity_err, output, 1, meaning parity mismatch on the delivered frame.
REQ-012 SHALL have port framing_err, output, 1, meaning a stop bit was sampled 0 on the delivered frame.
REQ-013 SHALL have port overrun, output, 1, meaning one or more frames were dropped, sticky.

Function
REQ-014 SHALL pass rcv through a 2-flop synchronizer; all sampling uses the synchronized value.
REQ-015 SHALL generate a one-cycle tick every CLKS_PER_TICK clocks; one bit period SHALL be 8 ticks.
REQ-016 SHALL implement states IDLE, START, DATA, PARITY, STOP, with PARITY skipped when PARITY_MODE=0.
REQ-017 In IDLE, a synchronized 1->0 transition SHALL enter START and zero the tick and bit-phase counters in that cycle.
REQ-018 In START at phase 4, a sample of 1 SHALL be treated as a false start and return to IDLE with no req; a sample of 0 SHALL continue to DATA.
REQ-019 Each bit SHALL be sampled at phase 4 of its period; data SHALL be shifted in LSB first and advance state at phase 7.
REQ-020 Parity SHALL be the XOR of the payload and the parity bit; a nonzero result in even mode, or zero in odd mode, SHALL set the parity error for that frame.
REQ-021 Each of the STOP_BITS stop bits SHALL be sampled; any 0 SHALL set the framing error for that frame.
REQ-022 After the mid-sample of the last stop bit, the FSM SHALL return to IDLE immediately, without waiting for end of bit.
REQ-023 The shift register and output register SHALL be separate so that reception continues while req is outstanding.
REQ-024 On frame completion with req=0 and ack=0, the design SHALL load data, parity_err and framing_err and drive req=1 on the next clock.
REQ-025 The handshake SHALL be four-phase: req stays 1 until ack=1 is sampled, then req=0 the next clock; a new req SHALL NOT be raised while ack=1.
REQ-026 data and the error flags SHALL be held stable while req=1.
REQ-027 On frame completion with req=1 or ack=1, the frame SHALL be discarded, overrun SHALL be set, and data SHALL be unchanged.
REQ-028 overrun SHALL clear only when a subsequent frame is loaded per REQ-024 or on reset.
REQ-029 The tick divider counter SHALL wrap from CLKS_PER_TICK-1 to 0, and the phase counter SHALL wrap from 7 to 0.

Reset
REQ-030 While clr=1 at a clock edge, the design SHALL set state=IDLE, all counters to 0, req=0, data=0, parity_err=0, framing_err=0 and overrun=0.
REQ-031 Reset mid-frame SHALL discard the partial frame; the synchronizer SHALL be preset to 1.
REQ-032 The first start edge SHALL be recognized no earlier than 3 clocks after clr deasserts.

Configuration
REQ-033 With RX_MAJORITY_EN defined, each bit, including start, parity and stop, SHALL be the 2-of-3 majority of samples at phases 3, 4 and 5, and the decision SHALL be taken at phase 5.
REQ-034 With RX_MAJORITY_EN undefined, each bit SHALL be a single sample at phase 4, with no vote logic present.

Verification
REQ-035 The bench SHALL cover: CLKS_PER_TICK=2, 8N1, send 0xA5, hold ack=0 -> data=0xA5, req=1, all error flags 0.
REQ-036 The bench SHALL cover: PARITY_MODE=1, send 0x07 with parity bit 1 -> parity_err=0; send 0x07 with parity bit 0 -> parity_err=1, data=0x07.
REQ-037 The bench SHALL cover: STOP_BITS=2, second stop bit driven 0 -> framing_err=1, req=1.
REQ-038 The bench SHALL cover: rcv low for 2 ticks then high -> no req; state returns to IDLE; a following frame 0x3C is received correctly.
REQ-039 The bench SHALL cover: send 0x11, then 0x22 with ack never asserted -> data=0x11, overrun=1; then ack, release, send 0x33 -> data=0x33, overrun=0.
REQ-040 The bench SHALL cover: clr=1 during DATA phase of 0xFF, then send 0x81 -> only 0x81 delivered; with RX_MAJORITY_EN, a 1-tick glitch at phase 4 of every bit -> 0x81 still received.
